// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-requester memory bus arbiter: FSM state
// encodings and the owner encoding used for grants and response routing.
package bus_arbiter_pkg;

  localparam int ARB_STATE_WIDTH = 2;

  typedef enum logic [ARB_STATE_WIDTH-1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_e;

  // Owner encoding doubles as the bit index into the req/gnt vectors.
  localparam logic ARB_OWNER_IF = 1'b0;
  localparam logic ARB_OWNER_DM = 1'b1;

endpackage

// File: rtl/bus_arbiter_rr2.sv
// arb_rr2: two-input round-robin picker, purely combinational.
//   req  [1:0]  request vector, bit 0 = IF, bit 1 = DM
//   last        owner that received the previous grant
//   gnt  [1:0]  one-hot grant (all zero when nothing requests)
// The last-grant history lives in the caller.
module arb_rr2
  import bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    // On a tie, favour whoever was not served last.
    if (&req) gnt = (last == ARB_OWNER_DM) ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one external memory bus between instruction fetch
// (if_*) and data load/store (dm_*). One transaction in flight at a time,
// sequenced by IDLE -> REQ -> WAIT, round-robin on ties.
//   clk, rst            clock, async active-low reset
//   if_req_*/if_rsp_*   fetch request (addr) / response pulse + data
//   dm_req_*/dm_rsp_*   data request (addr, we, wdata, wstrb) / response
//   bus_req_*/bus_rsp_* downstream memory bus request / response
//   bus_err             sticky: a bus response arrived with none pending
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_WIDTH-1:0] if_req_addr,
  output logic                  if_rsp_valid,
  output logic [DATA_WIDTH-1:0] if_rsp_data,
  input  logic                  dm_req_valid,
  output logic                  dm_req_ready,
  input  logic [ADDR_WIDTH-1:0] dm_req_addr,
  input  logic                  dm_req_we,
  input  logic [DATA_WIDTH-1:0] dm_req_wdata,
  input  logic [STRB_WIDTH-1:0] dm_req_wstrb,
  output logic                  dm_rsp_valid,
  output logic [DATA_WIDTH-1:0] dm_rsp_data,
  output logic                  bus_req_valid,
  input  logic                  bus_req_ready,
  output logic [ADDR_WIDTH-1:0] bus_req_addr,
  output logic                  bus_req_we,
  output logic [DATA_WIDTH-1:0] bus_req_wdata,
  output logic [STRB_WIDTH-1:0] bus_req_wstrb,
  input  logic                  bus_rsp_valid,
  input  logic [DATA_WIDTH-1:0] bus_rsp_data,
  output logic                  bus_err
);

  arb_state_e            state, state_nxt;
  logic                  owner, last_grant;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic                  cmd_we;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [STRB_WIDTH-1:0] cmd_wstrb;
  logic [1:0]            gnt;
  logic                  accept, stray;

  arb_rr2 u_rr (
    .req  ({dm_req_valid, if_req_valid}),
    .last (last_grant),
    .gnt  (gnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ARB_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    stray         = 1'b0;
    if_req_ready  = 1'b0;
    dm_req_ready  = 1'b0;
    bus_req_valid = 1'b0;
    if_rsp_valid  = 1'b0;
    dm_rsp_valid  = 1'b0;
    case (state)
      ARB_IDLE: begin
        accept       = |gnt;
        if_req_ready = gnt[ARB_OWNER_IF];
        dm_req_ready = gnt[ARB_OWNER_DM];
        stray        = bus_rsp_valid;
        if (accept) state_nxt = ARB_REQ;
      end
      ARB_REQ: begin
        bus_req_valid = 1'b1;
        stray         = bus_rsp_valid;
        if (bus_req_ready) state_nxt = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (bus_rsp_valid) begin
          if_rsp_valid = (owner == ARB_OWNER_IF);
          dm_rsp_valid = (owner == ARB_OWNER_DM);
          state_nxt    = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
    // State is already IDLE while reset is held, but the IDLE readies are
    // combinational on req_valid, so mask handshakes until reset releases.
    if (!rst) begin
      if_req_ready  = 1'b0;
      dm_req_ready  = 1'b0;
      bus_req_valid = 1'b0;
      if_rsp_valid  = 1'b0;
      dm_rsp_valid  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner      <= ARB_OWNER_IF;
      last_grant <= ARB_OWNER_DM;
      cmd_addr   <= '0;
      cmd_we     <= 1'b0;
      cmd_wdata  <= '0;
      cmd_wstrb  <= '0;
      bus_err    <= 1'b0;
    end else begin
      if (accept) begin
        owner      <= gnt[ARB_OWNER_DM];
        last_grant <= gnt[ARB_OWNER_DM];
        if (gnt[ARB_OWNER_DM]) begin
          cmd_addr  <= dm_req_addr;
          cmd_we    <= dm_req_we;
          cmd_wdata <= dm_req_wdata;
          cmd_wstrb <= dm_req_wstrb;
        end else begin
          // Fetches are always reads with no byte enables.
          cmd_addr  <= if_req_addr;
          cmd_we    <= 1'b0;
          cmd_wdata <= '0;
          cmd_wstrb <= '0;
        end
      end
      if (stray) bus_err <= 1'b1;
    end
  end

  assign bus_req_addr  = cmd_addr;
  assign bus_req_we    = cmd_we;
  assign bus_req_wdata = cmd_wdata;
  assign bus_req_wstrb = cmd_wstrb;
  assign if_rsp_data   = bus_rsp_data;
  assign dm_rsp_data   = bus_rsp_data;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed stimulus pushes expected bus
// requests and responses; a monitor pops and compares on each handshake.
module tb_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_valid, if_req_ready;
  logic [AW-1:0] if_req_addr;
  logic          if_rsp_valid;
  logic [DW-1:0] if_rsp_data;
  logic          dm_req_valid, dm_req_ready;
  logic [AW-1:0] dm_req_addr;
  logic          dm_req_we;
  logic [DW-1:0] dm_req_wdata;
  logic [SW-1:0] dm_req_wstrb;
  logic          dm_rsp_valid;
  logic [DW-1:0] dm_rsp_data;
  logic          bus_req_valid, bus_req_ready;
  logic [AW-1:0] bus_req_addr;
  logic          bus_req_we;
  logic [DW-1:0] bus_req_wdata;
  logic [SW-1:0] bus_req_wstrb;
  logic          bus_rsp_valid;
  logic [DW-1:0] bus_rsp_data;
  logic          bus_err;

  bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready),
    .if_req_addr(if_req_addr), .if_rsp_valid(if_rsp_valid),
    .if_rsp_data(if_rsp_data),
    .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready),
    .dm_req_addr(dm_req_addr), .dm_req_we(dm_req_we),
    .dm_req_wdata(dm_req_wdata), .dm_req_wstrb(dm_req_wstrb),
    .dm_rsp_valid(dm_rsp_valid), .dm_rsp_data(dm_rsp_data),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_req_addr(bus_req_addr), .bus_req_we(bus_req_we),
    .bus_req_wdata(bus_req_wdata), .bus_req_wstrb(bus_req_wstrb),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_data(bus_rsp_data),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_exp_t;

  typedef struct {
    logic        port;  // 0 = IF, 1 = DM
    logic [31:0] data;
  } rsp_exp_t;

  bus_exp_t exp_bus[$];
  rsp_exp_t exp_rsp[$];
  int   tests = 0;
  int   fails = 0;
  logic auto_rsp = 1'b1;
  logic stray = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event seen, none expected", name);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_bus(input logic [31:0] a, input logic we, input logic [31:0] wd,
                          input logic [3:0] ws);
    bus_exp_t e;
    e.addr = a; e.we = we; e.wdata = wd; e.wstrb = ws;
    exp_bus.push_back(e);
  endtask

  task automatic push_rsp(input logic port, input logic [31:0] d);
    rsp_exp_t r;
    r.port = port; r.data = d;
    exp_rsp.push_back(r);
  endtask

  // Memory contents the bus model returns.
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    case (a)
      32'h100: return 32'hDEAD_BEEF;
      32'h000: return 32'h0000_1111;
      32'h200: return 32'h2222_0200;
      32'h040: return 32'h4040_4040;
      32'h300: return 32'h3333_0300;
      default: return 32'hBAD0_0000;
    endcase
  endfunction

  // Bus model: responds one cycle after each accepted request; can also
  // inject a stray response on demand.
  initial begin
    logic          hs;
    logic [31:0]   hs_addr;
    bus_rsp_valid = 1'b0;
    bus_rsp_data  = '0;
    forever begin
      @(negedge clk);
      hs      = bus_req_valid && bus_req_ready;
      hs_addr = bus_req_addr;
      @(posedge clk);
      #1;
      bus_rsp_valid = (hs && auto_rsp) || stray;
      bus_rsp_data  = stray ? 32'h5757_5757 : mem_data(hs_addr);
    end
  end

  // Monitor / scoreboard.
  initial begin
    bus_exp_t e;
    rsp_exp_t r;
    forever begin
      @(negedge clk);
      if (bus_req_valid && bus_req_ready) begin
        if (exp_bus.size() == 0) flag("bus_unexpected");
        else begin
          e = exp_bus.pop_front();
          chk("bus_addr",  bus_req_addr,  e.addr);
          chk("bus_we",    {31'd0, bus_req_we}, {31'd0, e.we});
          chk("bus_wdata", bus_req_wdata, e.wdata);
          chk("bus_wstrb", {28'd0, bus_req_wstrb}, {28'd0, e.wstrb});
        end
      end
      if (if_rsp_valid && dm_rsp_valid) flag("rsp_both");
      else if (if_rsp_valid || dm_rsp_valid) begin
        if (exp_rsp.size() == 0) flag("rsp_unexpected");
        else begin
          r = exp_rsp.pop_front();
          chk("rsp_port", {31'd0, dm_rsp_valid}, {31'd0, r.port});
          chk("rsp_data", dm_rsp_valid ? dm_rsp_data : if_rsp_data, r.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    if_req_valid = 1'b1; if_req_addr = '0;
    dm_req_valid = 1'b0; dm_req_addr = '0; dm_req_we = 1'b0;
    dm_req_wdata = '0;   dm_req_wstrb = '0;
    bus_req_ready = 1'b1;
    #12;
    // Reset state, with a fetch request pending to show readies are masked.
    chk("rst_if_rdy",    if_req_ready,  0);
    chk("rst_dm_rdy",    dm_req_ready,  0);
    chk("rst_bus_valid", bus_req_valid, 0);
    chk("rst_bus_err",   bus_err,       0);
    chk("rst_bus_addr",  bus_req_addr,  0);
    chk("rst_if_rsp",    if_rsp_valid,  0);
    if_req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Contention: first tie to IF, then strict alternation every 3 cycles.
    tick;
    if_req_valid = 1'b1; if_req_addr = 32'h0;
    dm_req_valid = 1'b1; dm_req_addr = 32'h200; dm_req_we = 1'b0;
    dm_req_wdata = 32'hAAAA_5555; dm_req_wstrb = 4'hF;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        push_bus(32'h0, 1'b0, 32'h0, 4'h0);
        push_rsp(1'b0, 32'h0000_1111);
      end else begin
        push_bus(32'h200, 1'b0, 32'hAAAA_5555, 4'hF);
        push_rsp(1'b1, 32'h2222_0200);
      end
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("cont_if_rdy", if_req_ready, (k % 2 == 0) ? 1 : 0);
      chk("cont_dm_rdy", dm_req_ready, (k % 2 == 1) ? 1 : 0);
      tick;
      if (k == 3) begin
        if_req_valid = 1'b0;
        dm_req_valid = 1'b0;
      end
      tick;
      tick;
    end

    // Single fetch: ready at cycle 0, bus at cycle 1, response at cycle 2.
    if_req_valid = 1'b1; if_req_addr = 32'h100;
    push_bus(32'h100, 1'b0, 32'h0, 4'h0);
    push_rsp(1'b0, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("fetch_if_rdy", if_req_ready, 1);
    chk("fetch_dm_rdy", dm_req_ready, 0);
    tick;
    if_req_valid = 1'b0;
    @(negedge clk);
    chk("fetch_bus_valid", bus_req_valid, 1);
    chk("fetch_bus_addr",  bus_req_addr,  32'h100);
    chk("fetch_bus_we",    bus_req_we,    0);
    tick;
    @(negedge clk);
    chk("fetch_if_rsp", if_rsp_valid, 1);
    chk("fetch_dm_rsp", dm_rsp_valid, 0);
    tick;

    // Data write with a 4-cycle bus stall; IF waits behind it.
    bus_req_ready = 1'b0;
    dm_req_valid = 1'b1; dm_req_addr = 32'h40; dm_req_we = 1'b1;
    dm_req_wdata = 32'h1234_5678; dm_req_wstrb = 4'h3;
    if_req_valid = 1'b1; if_req_addr = 32'h300;
    push_bus(32'h40, 1'b1, 32'h1234_5678, 4'h3);
    push_rsp(1'b1, 32'h4040_4040);
    push_bus(32'h300, 1'b0, 32'h0, 4'h0);
    push_rsp(1'b0, 32'h3333_0300);
    @(negedge clk);
    chk("wr_dm_rdy", dm_req_ready, 1);
    chk("wr_if_rdy", if_req_ready, 0);
    tick;
    dm_req_valid = 1'b0; dm_req_wdata = 32'hFFFF_FFFF; dm_req_addr = 32'h999;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_valid", bus_req_valid, 1);
      chk("stall_addr",  bus_req_addr,  32'h40);
      chk("stall_we",    bus_req_we,    1);
      chk("stall_wdata", bus_req_wdata, 32'h1234_5678);
      chk("stall_wstrb", bus_req_wstrb, 4'h3);
      chk("stall_if_rdy", if_req_ready, 0);
      tick;
    end
    bus_req_ready = 1'b1;
    @(negedge clk);
    chk("wr_hs_if_rdy", if_req_ready, 0);
    tick;
    @(negedge clk);
    chk("wr_dm_rsp", dm_rsp_valid, 1);
    chk("wr_rsp_if_rdy", if_req_ready, 0);
    tick;
    @(negedge clk);
    chk("after_wr_if_rdy", if_req_ready, 1);
    tick;
    if_req_valid = 1'b0;
    tick;
    tick;

    // Stray response in IDLE.
    @(negedge clk);
    stray = 1'b1;
    tick;
    @(negedge clk);
    stray = 1'b0;
    chk("stray_if_rsp", if_rsp_valid, 0);
    chk("stray_dm_rsp", dm_rsp_valid, 0);
    tick;
    @(negedge clk);
    chk("stray_err", bus_err, 1);
    tick;
    if_req_valid = 1'b1; if_req_addr = 32'h100;
    push_bus(32'h100, 1'b0, 32'h0, 4'h0);
    push_rsp(1'b0, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("stray_fetch_rdy", if_req_ready, 1);
    tick;
    if_req_valid = 1'b0;
    tick;
    tick;
    @(negedge clk);
    chk("stray_err_sticky", bus_err, 1);

    // Reset during WAIT with both requesters valid.
    auto_rsp = 1'b0;
    tick;
    if_req_valid = 1'b1; if_req_addr = 32'h0;
    dm_req_valid = 1'b1; dm_req_addr = 32'h200; dm_req_we = 1'b0;
    dm_req_wdata = 32'hAAAA_5555; dm_req_wstrb = 4'hF;
    push_bus(32'h200, 1'b0, 32'hAAAA_5555, 4'hF);
    @(negedge clk);
    chk("mid_dm_rdy", dm_req_ready, 1);
    tick;
    tick;
    tick;
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_bus_valid", bus_req_valid, 0);
    chk("mid_rst_if_rdy",    if_req_ready,  0);
    chk("mid_rst_dm_rdy",    dm_req_ready,  0);
    chk("mid_rst_err",       bus_err,       0);
    auto_rsp = 1'b1;
    push_bus(32'h0, 1'b0, 32'h0, 4'h0);
    push_rsp(1'b0, 32'h0000_1111);
    push_bus(32'h200, 1'b0, 32'hAAAA_5555, 4'hF);
    push_rsp(1'b1, 32'h2222_0200);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_rst_if_rdy", if_req_ready, 1);
    chk("post_rst_dm_rdy", dm_req_ready, 0);
    tick;
    tick;
    tick;
    @(negedge clk);
    chk("post_rst_dm_next", dm_req_ready, 1);
    tick;
    if_req_valid = 1'b0;
    dm_req_valid = 1'b0;
    tick;
    tick;
    tick;

    chk("exp_bus_left", exp_bus.size(), 0);
    chk("exp_rsp_left", exp_rsp.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the core's single external memory bus between two requesters: instruction fetch (port `if_`) and data load/store (port `dm_`).
- Sits between the control unit/datapath and the memory interface.
- Exactly one transaction is outstanding at a time. A 3-state FSM sequences it, with round-robin arbitration on ties.
- Response data is routed back only to the requester that owns the transaction.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; must be a multiple of 8.
- STRB_WIDTH, DATA_WIDTH/8, byte-strobe width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req_valid  in  1  fetch request valid.
- if_req_ready  out  1  fetch request accepted.
- if_req_addr  in  ADDR_WIDTH  fetch address.
- if_rsp_valid  out  1  fetch response pulse.
- if_rsp_data  out  DATA_WIDTH  fetch read data.
- dm_req_valid  in  1  data request valid.
- dm_req_ready  out  1  data request accepted.
- dm_req_addr  in  ADDR_WIDTH  data address.
- dm_req_we  in  1  1 = write.
- dm_req_wdata  in  DATA_WIDTH  write data.
- dm_req_wstrb  in  STRB_WIDTH  byte enables.
- dm_rsp_valid  out  1  data response pulse (read data or write ack).
- dm_rsp_data  out  DATA_WIDTH  data read data.
- bus_req_valid  out  1  bus request valid.
- bus_req_ready  in  1  bus accepts request.
- bus_req_addr  out  ADDR_WIDTH  bus address.
- bus_req_we  out  1  bus write enable.
- bus_req_wdata  out  DATA_WIDTH  bus write data.
- bus_req_wstrb  out  STRB_WIDTH  bus byte enables.
- bus_rsp_valid  in  1  bus response valid.
- bus_rsp_data  in  DATA_WIDTH  bus response data.
- bus_err  out  1  sticky protocol-error flag.

Behaviour:
- FSM states: ARB_IDLE, ARB_REQ, ARB_WAIT. Reset state is ARB_IDLE.
- Reset values:
  - all valid/ready outputs 0;
  - bus_err 0;
  - latched cmd regs 0;
  - owner = IF;
  - last_grant = DM, so the first tie goes to IF.
- ARB_IDLE:
  - Grant is computed combinationally.
    - Only one requester valid: grant it.
    - Both valid: grant the one that is not last_grant.
  - Assert the granted requester's req_ready in the same cycle. The other requester's ready stays 0.
  - On that edge, latch addr/we/wdata/wstrb, owner and last_grant, then go to ARB_REQ.
  - IF requests latch we=0, wdata=0, wstrb=0.
  - req_ready is never asserted outside ARB_IDLE.
- ARB_REQ:
  - bus_req_valid=1, driven from the latched regs.
  - The latched regs stay stable until bus_req_ready.
  - When bus_req_ready=1, go to ARB_WAIT.
- ARB_WAIT:
  - When bus_rsp_valid=1:
    - Assert the owner's rsp_valid combinationally in the same cycle.
    - The owner's rsp_data = bus_rsp_data.
    - Go to ARB_IDLE.
  - The non-owner's rsp_valid stays 0.
  - Both rsp_data outputs always pass bus_rsp_data through; consumers qualify with rsp_valid.
- Response channel has no backpressure: requesters must accept rsp_valid pulses.
- Writes also receive exactly one response (ack); its data is don't-care.
- Minimum round trip, with bus ready and response back-to-back:
  - accept at cycle 0;
  - bus_req_valid at cycle 1;
  - response at cycle 2 at the earliest;
  - next accept at cycle 3.
- A requester held valid by itself is served every 3 cycles minimum. Two contending requesters alternate strictly.
- bus_err:
  - Set if bus_rsp_valid=1 while in ARB_IDLE or ARB_REQ. The response is dropped and the state is unchanged.
  - Cleared only by reset.
- Reset asserted mid-transaction:
  - Return immediately to ARB_IDLE and drop the latched transaction.
  - Any later stray bus response sets bus_err; requesters must reissue their requests.
- A requester dropping req_valid before ready is legal; no grant is recorded.

Decomposition:
- copperv_h.v gets:
  - ARB_STATE_WIDTH and the ARB_IDLE/ARB_REQ/ARB_WAIT encodings;
  - ARB_OWNER_IF=0 and ARB_OWNER_DM=1.
- One sub-module, arb_rr2: a 2-input round-robin picker.
  - Inputs: req[1:0], last.
  - Output: one-hot gnt.
  - Purely combinational; last_grant is held in bus_arbiter.

Test Plan:
- Single fetch:
  - Stimulus: if_req_valid with addr 0x100; bus ready immediately; response 0xDEADBEEF one cycle later.
  - Required: if_req_ready at cycle 0; bus_req_addr=0x100 with we=0 at cycle 1; if_rsp_valid with data 0xDEADBEEF at cycle 2; dm_rsp_valid never asserted.
- Contention:
  - Stimulus: both requesters valid continuously after reset (IF addr 0x0, DM addr 0x200).
  - Required: grants ordered IF, DM, IF, DM; bus addresses 0x0, 0x200, 0x0, 0x200.
- Data write:
  - Stimulus: dm write, addr 0x40, wdata 0x12345678, wstrb 0x3; bus_req_ready held low for 4 cycles.
  - Required: bus fields stay stable for all 4 stall cycles; a single dm_rsp_valid after the response; if_req_ready stays 0 throughout even with if_req_valid high.
- Stray response:
  - Stimulus: bus_rsp_valid pulse while in ARB_IDLE.
  - Required: bus_err=1 and stays 1; no rsp_valid on either port; the next fetch still completes normally.
- Reset mid-transaction:
  - Stimulus: assert rst=0 asynchronously during ARB_WAIT.
  - Required: bus_req_valid and all readies drop without waiting for a clock edge; after release, the state is ARB_IDLE and IF wins the first tie.
